optical_frame_gen: RTL and testbench

Parametrised serial frame generator for the optical link transmitter. Accepts a DATA_W-bit pattern over a valid/ready handshake and emits a start bit, the data bits LSB first, an optional parity bit, and one or two stop bits on a single on/off-keyed line. Each bit is held for CLKS_PER_BIT clock cycles. A repeat mode retransmits the last accepted pattern back-to-back with no idle gap. It feeds the laser modulator driver directly.

---
 rtl/optical_frame_gen.sv | 186 ++++++++++++++++++
 tb/tb_optical_frame_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/optical_frame_gen.sv
// optical_frame_gen: serial frame generator for the optical link transmitter.
// Each frame is a start bit, DATA_W data bits sent LSB first, an optional even-parity
// bit and STOP_BITS stop bits. Every line bit lasts CLKS_PER_BIT cycles.
// Build option: define OPT_FRAME_PARITY_EN to insert the even-parity bit.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   pattern_data   pattern captured when pattern_valid && pattern_ready
//   pattern_valid  pattern_data is valid
//   pattern_ready  a pattern can be accepted this cycle (IDLE or last stop cycle)
//   repeat_en      resend the latched pattern back-to-back while high
//   out_bit        serial line output (on/off keyed)
//   busy           high in every state except IDLE
//   frame_done     one-cycle pulse on the final cycle of the final stop bit
`timescale 1ns/1ps
module optical_frame_gen #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter logic        IDLE_LEVEL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pattern_data,
    input  logic              pattern_valid,
    output logic              pattern_ready,
    input  logic              repeat_en,
    output logic              out_bit,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef OPT_FRAME_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   data_sh;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                xfer;
    logic                bit_end;
    logic                last_d;

    // ready_q always equals the decode of the current state/counters
    assign xfer    = pattern_valid && ready_q;
    assign bit_end = (cyc_q == CYC_LAST);

    // Next state, counters and output values; outputs are decoded from the next state
    // so that the registered outputs line up with the registered state.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q + CYC_W'(1);
        bit_d    = bit_q;
        shadow_d = shadow_q;
        out_d    = IDLE_LEVEL;
        data_sh  = '0;

        if (xfer) begin
            shadow_d = pattern_data;
        end

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (xfer) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
`ifdef OPT_FRAME_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef OPT_FRAME_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // new transfer wins over repeat; both restart with no gap
                        if (xfer || repeat_en) begin
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Line level for the upcoming cycle
        data_sh = shadow_d >> bit_d;
        case (state_d)
            S_START:  out_d = ~IDLE_LEVEL;
            S_DATA:   out_d = data_sh[0];
`ifdef OPT_FRAME_PARITY_EN
            S_PARITY: out_d = ^shadow_d;
`endif
            default:  out_d = IDLE_LEVEL;
        endcase

        busy_d  = (state_d != S_IDLE);
        last_d  = (state_d == S_STOP) && (cyc_d == CYC_LAST) && (bit_d == STOP_LAST);
        done_d  = last_d;
        ready_d = (state_d == S_IDLE) || last_d;
    end

    // State, counters, shadow pattern and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            out_q    <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign out_bit       = out_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign pattern_ready = ready_q;

endmodule

// File: tb/tb_optical_frame_gen.sv
// tb_optical_frame_gen: directed bench for optical_frame_gen with a frame-position model.
// Instance A: DATA_W=8, CLKS_PER_BIT=1, STOP_BITS=1. Instance B: CLKS_PER_BIT=4, STOP_BITS=2.
`timescale 1ns/1ps
module tb_optical_frame_gen;

`ifdef OPT_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FLA = 10 + PB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] da, db;
    logic       va, vb, ra, rb;
    logic       ready_a, out_a, busy_a, done_a;
    logic       ready_b, out_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    optical_frame_gen #(.DATA_W(8), .CLKS_PER_BIT(1), .STOP_BITS(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .pattern_data(da), .pattern_valid(va),
        .pattern_ready(ready_a), .repeat_en(ra), .out_bit(out_a), .busy(busy_a),
        .frame_done(done_a)
    );

    optical_frame_gen #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pattern_data(db), .pattern_valid(vb),
        .pattern_ready(ready_b), .repeat_en(rb), .out_bit(out_b), .busy(busy_b),
        .frame_done(done_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int flen(input int cpb, input int stops);
        return (1 + 8 + PB + stops) * cpb;
    endfunction

    // {out_bit, busy, frame_done} at cycle position pos within a frame of pattern d
    function automatic logic [2:0] exp_cyc(input logic [7:0] d, input int pos,
                                           input int cpb, input int stops);
        int   slot;
        logic o;
        slot = pos / cpb;
        if (slot == 0)                 o = 1'b1;
        else if (slot <= 8)            o = d[slot-1];
        else if (PB == 1 && slot == 9) o = ^d;
        else                           o = 1'b0;
        return {o, 1'b1, (pos == flen(cpb, stops) - 1)};
    endfunction

    // Model: each instance is either idle or at a cycle position inside a frame
    logic       act_a, act_b;
    int         pos_a, pos_b;
    logic [7:0] sh_a, sh_b;
    logic       last_a, last_b, xfer_a, xfer_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_a = 1'b0; pos_a = 0; sh_a = 8'h00;
        end else begin
            last_a = act_a && (pos_a == flen(1, 1) - 1);
            xfer_a = va && (!act_a || last_a);
            if (xfer_a) begin
                act_a = 1'b1; pos_a = 0; sh_a = da;
            end else if (last_a && ra) begin
                pos_a = 0;
            end else if (last_a) begin
                act_a = 1'b0; pos_a = 0;
            end else if (act_a) begin
                pos_a++;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_b = 1'b0; pos_b = 0; sh_b = 8'h00;
        end else begin
            last_b = act_b && (pos_b == flen(4, 2) - 1);
            xfer_b = vb && (!act_b || last_b);
            if (xfer_b) begin
                act_b = 1'b1; pos_b = 0; sh_b = db;
            end else if (last_b && rb) begin
                pos_b = 0;
            end else if (last_b) begin
                act_b = 1'b0; pos_b = 0;
            end else if (act_b) begin
                pos_b++;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    logic [2:0] ea, eb;
    always @(negedge clk) begin
        if (chk_en) begin
            ea = act_a ? exp_cyc(sh_a, pos_a, 1, 1) : 3'b000;
            eb = act_b ? exp_cyc(sh_b, pos_b, 4, 2) : 3'b000;
            chk("a_out",   64'(out_a),   64'(ea[2]));
            chk("a_busy",  64'(busy_a),  64'(ea[1]));
            chk("a_done",  64'(done_a),  64'(ea[0]));
            chk("a_ready", 64'(ready_a), 64'(!act_a || ea[0]));
            chk("b_out",   64'(out_b),   64'(eb[2]));
            chk("b_busy",  64'(busy_b),  64'(eb[1]));
            chk("b_done",  64'(done_b),  64'(eb[0]));
            chk("b_ready", 64'(ready_b), 64'(!act_b || eb[0]));
        end
    end

    task automatic send_a(input logic [7:0] d);
        @(posedge clk); #1 va = 1'b1; da = d;
        @(posedge clk); #1 va = 1'b0;
    endtask

    task automatic cap_a(input int n, output logic [31:0] seq, output int dpos);
        seq  = '0;
        dpos = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            seq = {seq[30:0], out_a};
            if (done_a && dpos < 0) dpos = k;
        end
    endtask

    logic [31:0] seq;
    int          dpos, nb, nd, nh;
    logic        rdy_last;

    initial begin
        rst_n = 1'b1; va = 1'b0; vb = 1'b0; ra = 1'b0; rb = 1'b0; da = '0; db = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst_ready", 64'(ready_a), 64'd1);
        chk("rst_busy",  64'(busy_a),  64'd0);
        chk("rst_out",   64'(out_a),   64'd0);
        chk("rst_done",  64'(done_a),  64'd0);

        // Basic frame 8'b10011010
        send_a(8'h9A);
        cap_a(FLA, seq, dpos);
`ifdef OPT_FRAME_PARITY_EN
        chk("basic_seq", 64'(seq), 64'(11'b10101100100));
`else
        chk("basic_seq", 64'(seq), 64'(10'b1010110010));
`endif
        chk("basic_done_pos", 64'(dpos), 64'(FLA - 1));
        @(negedge clk);
        chk("basic_idle_out", 64'(out_a),   64'd0);
        chk("basic_ready",    64'(ready_a), 64'd1);

        // Single low-order bit: parity bit is 1 when enabled
        send_a(8'h01);
        cap_a(FLA, seq, dpos);
`ifdef OPT_FRAME_PARITY_EN
        chk("p01_seq", 64'(seq), 64'(11'b11000000010));
`else
        chk("p01_seq", 64'(seq), 64'(10'b1100000000));
`endif

        // Repeat mode: three frames back-to-back, repeat dropped inside frame 3
        @(posedge clk); #1 ra = 1'b1;
        send_a(8'h5A);
        nb = 0; nd = 0; dpos = -1;
        for (int k = 0; k < 3 * FLA + 8; k++) begin
            @(negedge clk);
            if (busy_a) nb++;
            if (done_a) nd++;
            if (!busy_a && dpos < 0) dpos = k;
            if (k == 2 * FLA + 4) ra = 1'b0;
        end
        chk("rep_done_cnt",  64'(nd),   64'd3);
        chk("rep_busy_cnt",  64'(nb),   64'(3 * FLA));
        chk("rep_first_idle", 64'(dpos), 64'(3 * FLA));

        // Back-to-back handshake with valid held high
        @(posedge clk); #1 va = 1'b1; da = 8'h0F;
        @(posedge clk); #1 da = 8'hF0;
        seq = '0; rdy_last = 1'b0;
        for (int k = 0; k < 2 * FLA; k++) begin
            @(negedge clk);
            seq = {seq[30:0], out_a};
            if (k == FLA - 1) rdy_last = ready_a && done_a;
            if (k == 2 * FLA - 1) va = 1'b0;
        end
`ifdef OPT_FRAME_PARITY_EN
        chk("b2b_seq", 64'(seq), 64'(22'b1111100000010000111100));
`else
        chk("b2b_seq", 64'(seq), 64'(20'b11111000001000011110));
`endif
        chk("b2b_ready_last", 64'(rdy_last), 64'd1);

        // Reset asserted during data bit 3, checked before any clock edge
        send_a(8'hA5);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_busy", 64'(busy_a), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out",   64'(out_a),   64'd0);
        chk("async_rst_busy",  64'(busy_a),  64'd0);
        chk("async_rst_ready", 64'(ready_a), 64'd1);
        chk("async_rst_done",  64'(done_a),  64'd0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        send_a(8'hA5);
        cap_a(FLA, seq, dpos);
`ifdef OPT_FRAME_PARITY_EN
        chk("rst_recover_seq", 64'(seq), 64'(11'b11010010100));
`else
        chk("rst_recover_seq", 64'(seq), 64'(10'b1101001010));
`endif
        chk("rst_recover_done", 64'(dpos), 64'(FLA - 1));

        // Stretched bits, two stop bits on instance B
        @(posedge clk); #1 vb = 1'b1; db = 8'hFF;
        @(posedge clk); #1 vb = 1'b0;
        nb = 0; nh = 0; nd = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (busy_b) nb++;
            if (busy_b && out_b) nh++;
            if (done_b) nd++;
        end
        chk("b_busy_cnt", 64'(nb), 64'(44 + 4 * PB));
        chk("b_high_cnt", 64'(nh), 64'd36);
        chk("b_done_cnt", 64'(nd), 64'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
